// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared FSM encoding and PC constants for the instruction fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [15:0] PC_STEP          = 16'd2;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    // 16-bit add wraps 16'hFFFE to 16'h0000 on its own
    function automatic logic [15:0] next_pc(input logic [15:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - synchronous FIFO holding {address, word} prefetch entries
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch FSM, PC and IR delivery; FETCH_MISALIGN_TRAP_EN adds a misaligned-redirect trap
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        input_Fetch_En,
    input  logic        input_Fetch_Next,
    input  logic        input_PC_Load,
    input  logic [15:0] input_PC_Value,
    input  logic [15:0] input_Mem_Data,
    input  logic        input_Mem_Valid,
    output logic        Output_Mem_Req,
    output logic [15:0] Output_Mem_Addr,
    output logic [15:0] Output_IR_Instru,
    output logic        Output_IR_Write,
    output logic [15:0] Output_Fetch_PC,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        Output_Fetch_Misalign,
`endif
    output logic        Output_Fetch_Ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [15:0]      pc_q, pc_d;
    logic [15:0]      mem_addr_q, mem_addr_d;
    logic             ir_write_q, ir_write_d;
    logic [15:0]      ir_instru_q, ir_instru_d;
    logic [15:0]      ir_pc_q, ir_pc_d;

    logic             buf_push, buf_pop, buf_flush;
    logic [31:0]      buf_rdata;
    logic [CNT_W-1:0] buf_count;
    logic [15:0]      load_pc;
    logic             trap_block;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = misalign_q;
        if (input_PC_Load) begin
            misalign_d = input_PC_Value[0];
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) misalign_q <= 1'b0;
        else       misalign_q <= misalign_d;
    end

    assign load_pc               = input_PC_Value;
    assign trap_block            = misalign_q;
    assign Output_Fetch_Misalign = misalign_q;
`else
    assign load_pc    = input_PC_Value & ~16'h0001;
    assign trap_block = 1'b0;
`endif

    fetch_buffer #(.DEPTH(DEPTH), .WIDTH(32)) u_buffer (
        .clk     (CLK),
        .reset   (Reset),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .flush_i (buf_flush),
        .wdata_i ({mem_addr_q, input_Mem_Data}),
        .rdata_o (buf_rdata),
        .count_o (buf_count)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mem_addr_d  = mem_addr_q;
        ir_write_d  = 1'b0;
        ir_instru_d = ir_instru_q;
        ir_pc_d     = ir_pc_q;
        buf_push    = 1'b0;
        buf_pop     = 1'b0;
        buf_flush   = 1'b0;

        if (!input_PC_Load && input_Fetch_Next && (buf_count != '0)) begin
            buf_pop     = 1'b1;
            ir_write_d  = 1'b1;
            ir_instru_d = buf_rdata[15:0];
            ir_pc_d     = buf_rdata[31:16];
        end

        case (state_q)
            IDLE: begin
                // buffer count already includes nothing outstanding while idle
                if (input_Fetch_En && !input_PC_Load && !trap_block &&
                    (buf_count < CNT_W'(DEPTH))) begin
                    state_d    = WAIT;
                    mem_addr_d = pc_q;
                end
            end
            WAIT: begin
                if (input_Mem_Valid) begin
                    if (!input_PC_Load) begin
                        buf_push = 1'b1;
                        pc_d     = next_pc(pc_q);
                    end
                    state_d = IDLE;
                end else if (input_PC_Load) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (input_Mem_Valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (input_PC_Load) begin
            buf_flush = 1'b1;
            pc_d      = load_pc;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            mem_addr_q  <= RESET_PC;
            ir_write_q  <= 1'b0;
            ir_instru_q <= 16'h0000;
            ir_pc_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_addr_q  <= mem_addr_d;
            ir_write_q  <= ir_write_d;
            ir_instru_q <= ir_instru_d;
            ir_pc_q     <= ir_pc_d;
        end
    end

    assign Output_Mem_Req     = (state_q != IDLE);
    assign Output_Mem_Addr    = mem_addr_q;
    assign Output_IR_Write    = ir_write_q;
    assign Output_IR_Instru   = ir_instru_q;
    assign Output_Fetch_PC    = ir_pc_q;
    assign Output_Fetch_Ready = (buf_count != '0);

endmodule
